// File: rtl/serv_axi_loader.sv
// serv_axi_loader: streams a boot image into SERV core RAM through single-beat
// AXI writes at incrementing word addresses. The core is held in reset until
// every word has been written and acknowledged. Bus errors and image overflow
// abort the load.
module serv_axi_loader #(
   parameter int AW        = 13,
   parameter int MEMSIZE   = 8192,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [31:0]   i_load_data,
   input  logic          i_load_valid,
   input  logic          i_load_last,
   output logic          o_load_ready,
   output logic [AW-1:0] o_awaddr,
   output logic          o_awvalid,
   input  logic          i_awready,
   output logic [31:0]   o_wdata,
   output logic [3:0]    o_wstrb,
   output logic          o_wvalid,
   input  logic          i_wready,
   input  logic [1:0]    i_bresp,
   input  logic          i_bvalid,
   output logic          o_bready,
   output logic          o_core_rst,
   output logic          o_done,
   output logic          o_error,
   output logic [AW-2:0] o_word_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_WRITE  = 3'd2;
   localparam logic [2:0] S_RESP   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   localparam int            NWORDS = MEMSIZE / 4;
   localparam logic [AW-1:0] BASE   = AW'(BASE_ADDR);
   localparam logic [AW-1:0] CAP    = AW'(NWORDS);

   logic [2:0]    state_reg;
   logic [AW-1:0] addr_reg;
   logic [AW-2:0] count_reg;
   logic [31:0]   data_reg;
   logic          last_reg;
   logic          ready_reg;
   logic          awvalid_reg;
   logic          wvalid_reg;
   logic          bready_reg;
   logic          core_rst_reg;
   logic          done_reg;
   logic          error_reg;
   logic          ram_full;
   logic          aw_settled;
   logic          w_settled;

   // The overflow test uses the acknowledged-word count rather than the
   // address: with MEMSIZE == 2**AW the address register rolls to BASE right
   // after the last legal word, but the count still says the RAM is full, so
   // no write is ever issued to a wrapped address.
   assign ram_full = {1'b0, count_reg} >= CAP;

   // A channel is finished once its valid is low or it handshakes this cycle.
   assign aw_settled = !awvalid_reg || i_awready;
   assign w_settled  = !wvalid_reg  || i_wready;

   // Load sequencer: every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         addr_reg     <= BASE;
         count_reg    <= '0;
         data_reg     <= '0;
         last_reg     <= 1'b0;
         ready_reg    <= 1'b0;
         awvalid_reg  <= 1'b0;
         wvalid_reg   <= 1'b0;
         bready_reg   <= 1'b0;
         core_rst_reg <= 1'b1;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  state_reg    <= S_ACCEPT;
                  addr_reg     <= BASE;
                  count_reg    <= '0;
                  ready_reg    <= 1'b1;
                  core_rst_reg <= 1'b1;
                  done_reg     <= 1'b0;
                  error_reg    <= 1'b0;
               end
            end
            S_ACCEPT: begin
               if (i_load_valid) begin
                  data_reg  <= i_load_data;
                  last_reg  <= i_load_last;
                  ready_reg <= 1'b0;
                  if (ram_full) begin
                     state_reg <= S_ERROR;
                     error_reg <= 1'b1;
                  end else begin
                     state_reg   <= S_WRITE;
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               awvalid_reg <= awvalid_reg && !i_awready;
               wvalid_reg  <= wvalid_reg && !i_wready;
               if (aw_settled && w_settled) begin
                  state_reg  <= S_RESP;
                  bready_reg <= 1'b1;
               end
            end
            S_RESP: begin
               if (i_bvalid) begin
                  bready_reg <= 1'b0;
                  if (i_bresp != 2'b00) begin
                     state_reg <= S_ERROR;
                     error_reg <= 1'b1;
                  end else begin
                     count_reg <= count_reg + 1'b1;
                     addr_reg  <= addr_reg + AW'(4);
                     if (last_reg) begin
                        state_reg    <= S_DONE;
                        core_rst_reg <= 1'b0;
                        done_reg     <= 1'b1;
                     end else begin
                        state_reg <= S_ACCEPT;
                        ready_reg <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign o_load_ready = ready_reg;
   assign o_awaddr     = addr_reg;
   assign o_awvalid    = awvalid_reg;
   assign o_wdata      = data_reg;
   assign o_wstrb      = 4'hF;
   assign o_wvalid     = wvalid_reg;
   assign o_bready     = bready_reg;
   assign o_core_rst   = core_rst_reg;
   assign o_done       = done_reg;
   assign o_error      = error_reg;
   assign o_word_count = count_reg;

endmodule

// File: tb/tb_serv_axi_loader.sv
// tb_serv_axi_loader: randomized image loads against a small AXI slave model;
// expected write addresses, data, counts and final status come from the
// image length, last flag, error word and RAM capacity.
module tb_serv_axi_loader;

   localparam int AW        = 13;
   localparam int MEMSIZE   = 16;
   localparam int BASE_ADDR = 0;
   localparam int CAP       = MEMSIZE / 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [31:0]   i_load_data;
   logic          i_load_valid;
   logic          i_load_last;
   logic          o_load_ready;
   logic [AW-1:0] o_awaddr;
   logic          o_awvalid;
   logic          i_awready;
   logic [31:0]   o_wdata;
   logic [3:0]    o_wstrb;
   logic          o_wvalid;
   logic          i_wready;
   logic [1:0]    i_bresp;
   logic          i_bvalid;
   logic          o_bready;
   logic          o_core_rst;
   logic          o_done;
   logic          o_error;
   logic [AW-2:0] o_word_count;

   int n_vec = 0;
   int n_err = 0;
   int n_load = 0;

   always #5 clk = ~clk;

   serv_axi_loader #(.AW(AW), .MEMSIZE(MEMSIZE), .BASE_ADDR(BASE_ADDR)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_load_data  (i_load_data),
      .i_load_valid (i_load_valid),
      .i_load_last  (i_load_last),
      .o_load_ready (o_load_ready),
      .o_awaddr     (o_awaddr),
      .o_awvalid    (o_awvalid),
      .i_awready    (i_awready),
      .o_wdata      (o_wdata),
      .o_wstrb      (o_wstrb),
      .o_wvalid     (o_wvalid),
      .i_wready     (i_wready),
      .i_bresp      (i_bresp),
      .i_bvalid     (i_bvalid),
      .o_bready     (o_bready),
      .o_core_rst   (o_core_rst),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_word_count (o_word_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      i_start      = 1'b0;
      i_load_valid = 1'b0;
      i_load_last  = 1'b0;
      i_load_data  = '0;
      i_awready    = 1'b0;
      i_wready     = 1'b0;
      i_bvalid     = 1'b0;
      i_bresp      = 2'b00;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("start_core_rst", o_core_rst, 1);
      check("start_ready", o_load_ready, 1);
      check("start_done", o_done, 0);
      check("start_error", o_error, 0);
      check("start_count", o_word_count, 0);
   endtask

   // One complete load: nwords offered, optional last on the final word,
   // err_word = index of the write that gets a non-OKAY response (-1: none).
   task automatic run_load(input int nwords, input bit with_last, input int err_word, input int max_dly);
      logic [31:0] img [0:7];
      int idx = 0, acc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, cycles = 0;
      int aw_wait, w_wait, b_wait;
      int exp_writes, exp_count, exp_acc;
      bit exp_err, b_hs_prev = 0;
      bit pv_aw = 0, pv_aw_hs = 0, pv_w = 0, pv_w_hs = 0;
      logic [AW-1:0] pv_addr = '0;
      logic [31:0]   pv_data = '0;

      for (int i = 0; i < 8; i++) img[i] = $urandom;
      aw_wait = $urandom_range(0, max_dly);
      w_wait  = $urandom_range(0, max_dly);
      b_wait  = $urandom_range(0, max_dly);

      if (err_word >= 0 && err_word < nwords && err_word < CAP) begin
         exp_writes = err_word + 1; exp_count = err_word; exp_acc = err_word + 1; exp_err = 1;
      end else if (nwords > CAP) begin
         exp_writes = CAP; exp_count = CAP; exp_acc = CAP + 1; exp_err = 1;
      end else begin
         exp_writes = nwords; exp_count = nwords; exp_acc = nwords; exp_err = 0;
      end

      pulse_start();

      while (1) begin
         if (b_hs_prev && !exp_err && b_cnt == exp_writes) begin
            check("release_core_rst", o_core_rst, 0);
            check("release_done", o_done, 1);
         end
         if (pv_aw_hs) check("aw_drop", o_awvalid, 0);
         if (pv_aw && !pv_aw_hs) begin
            check("aw_hold", o_awvalid, 1);
            check("aw_addr_stable", o_awaddr, pv_addr);
         end
         if (pv_w_hs) check("w_drop", o_wvalid, 0);
         if (pv_w && !pv_w_hs) begin
            check("w_hold", o_wvalid, 1);
            check("w_data_stable", o_wdata, pv_data);
         end
         if (o_done || o_error) break;
         if (cycles >= 600) begin
            check("load_timeout", o_done | o_error, 1);
            break;
         end

         // ignored start pulses while a write is in flight
         i_start = (o_awvalid || o_wvalid) && ($urandom_range(0, 3) == 0);

         // write response channel: only after both AW and W of a word
         if (b_hs_prev) i_bvalid = 1'b0;
         b_hs_prev = 0;
         if (!i_bvalid && ((aw_cnt < w_cnt ? aw_cnt : w_cnt) > b_cnt)) begin
            if (b_wait == 0) begin
               i_bvalid = 1'b1;
               i_bresp  = (b_cnt == err_word) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
               b_wait--;
            end
         end
         if (i_bvalid && o_bready) begin
            check("b_core_rst_held", o_core_rst, 1);
            b_cnt++;
            b_hs_prev = 1;
            b_wait = $urandom_range(0, max_dly);
         end

         // address channel
         pv_aw = o_awvalid; pv_addr = o_awaddr;
         if (o_awvalid) begin
            if (aw_wait == 0) i_awready = 1'b1;
            else begin i_awready = 1'b0; aw_wait--; end
         end else begin
            i_awready = 1'($urandom_range(0, 1));
         end
         pv_aw_hs = o_awvalid && i_awready;
         if (pv_aw_hs) begin
            check("aw_addr", o_awaddr, BASE_ADDR + 4 * aw_cnt);
            aw_cnt++;
            aw_wait = $urandom_range(0, max_dly);
         end

         // data channel
         pv_w = o_wvalid; pv_data = o_wdata;
         if (o_wvalid) begin
            if (w_wait == 0) i_wready = 1'b1;
            else begin i_wready = 1'b0; w_wait--; end
         end else begin
            i_wready = 1'($urandom_range(0, 1));
         end
         pv_w_hs = o_wvalid && i_wready;
         if (pv_w_hs) begin
            check("w_data", o_wdata, img[w_cnt]);
            check("w_strb", o_wstrb, 4'hF);
            w_cnt++;
            w_wait = $urandom_range(0, max_dly);
         end

         // image stream
         if (idx < nwords) begin
            i_load_valid = 1'b1;
            i_load_data  = img[idx];
            i_load_last  = with_last && (idx == nwords - 1);
         end else begin
            i_load_valid = 1'($urandom_range(0, 1));
            i_load_data  = $urandom;
            i_load_last  = 1'b0;
         end
         if (i_load_valid && o_load_ready) begin
            acc++;
            if (idx < nwords) idx++;
         end

         @(negedge clk);
         cycles++;
      end

      idle_inputs();
      check("end_error", o_error, exp_err);
      check("end_done", o_done, !exp_err);
      check("end_core_rst", o_core_rst, exp_err);
      check("end_count", o_word_count, exp_count);
      check("aw_total", aw_cnt, exp_writes);
      check("w_total", w_cnt, exp_writes);
      check("b_total", b_cnt, exp_writes);
      check("accepted_total", acc, exp_acc);

      // terminal state: stream refused, no new writes, count frozen
      i_load_valid = 1'b1;
      i_load_data  = $urandom;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_ready", o_load_ready, 0);
         check("post_awvalid", o_awvalid, 0);
      end
      check("post_count", o_word_count, exp_count);
      i_load_valid = 1'b0;

      n_load++;
      $display("load %0d: words=%0d last=%0b err_at=%0d writes=%0d count=%0d done=%0b error=%0b",
               n_load, nwords, with_last, err_word, aw_cnt, o_word_count, o_done, o_error);
   endtask

   task automatic reset_mid_write();
      int cycles = 0;
      pulse_start();
      i_load_valid = 1'b1;
      i_load_data  = $urandom;
      i_load_last  = 1'b0;
      while (!o_awvalid && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check("rst_test_awvalid_seen", o_awvalid, 1);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_awvalid", o_awvalid, 0);
      check("rst_wvalid", o_wvalid, 0);
      check("rst_bready", o_bready, 0);
      check("rst_core_rst", o_core_rst, 1);
      check("rst_ready", o_load_ready, 0);
      check("rst_count", o_word_count, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_idle_ready", o_load_ready, 0);
      end
      idle_inputs();
      n_load++;
      $display("load %0d: reset asserted during write", n_load);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("init_core_rst", o_core_rst, 1);
      check("init_done", o_done, 0);
      check("init_error", o_error, 0);
      check("init_ready", o_load_ready, 0);
      check("init_awvalid", o_awvalid, 0);
      check("init_wvalid", o_wvalid, 0);
      check("init_bready", o_bready, 0);
      check("init_count", o_word_count, 0);
      rst = 1'b0;

      run_load(4, 1'b1, -1, 0);   // all channels ready
      run_load(4, 1'b1, -1, 5);   // stalled AW/W/B
      run_load(4, 1'b1, 1, 3);    // second word gets an error response
      run_load(5, 1'b0, -1, 1);   // image larger than RAM
      run_load(4, 1'b1, -1, 0);
      run_load(1, 1'b1, -1, 0);   // single-word restart from DONE
      reset_mid_write();
      run_load(2, 1'b1, -1, 2);   // start from IDLE after reset

      for (int t = 0; t < 25; t++) begin
         int n, e;
         bit wl;
         n  = $urandom_range(1, 5);
         wl = (n <= CAP) ? 1'b1 : 1'($urandom_range(0, 1));
         e  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         run_load(n, wl, e, $urandom_range(0, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
